// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Each transaction: grant, WAIT_CYCLES of RAM access, then a one-cycle response.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic       arb_clk,
    input  logic       arb_rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rdata,
    output logic       busy,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       ram_we,
    input  logic [7:0] ram_rdata
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("mem_arbiter: WAIT_CYCLES must be 1..15");
    end

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       last_q, last_d;
    logic       owner_q, owner_d;
    logic       we_q, we_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic       win;

    // Tie goes to the port that was not granted last.
    always_comb begin
        win = ~req0;
        if (req0 && req1) begin
            win = ~last_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        done0_d = done0_q;
        done1_d = done1_q;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_LD;
                    owner_d = win;
                    we_d    = win ? we1 : we0;
                    addr_d  = win ? addr1 : addr0;
                    wdata_d = win ? wdata1 : wdata0;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    if (!we_q) begin
                        rdata_d = ram_rdata;
                    end
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                end
            end
            RESP: begin
                state_d = IDLE;
                last_d  = owner_q;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                done0_d = 1'b0;
                done1_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge arb_clk or negedge arb_rst_n) begin
        if (!arb_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
        end
    end

    // RAM side decodes straight from state so reset clears it at once.
    assign busy      = (state_q != IDLE);
    assign ram_addr  = busy ? addr_q : 8'h00;
    assign ram_wdata = busy ? wdata_q : 8'h00;
    assign ram_we    = (state_q == ACCESS) && (cnt_q == WAIT_LD) && we_q;
    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus reset,
// round-robin, mid-transaction drop and WAIT_CYCLES latency sequences.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1, busy, ram_we;
    logic [7:0] rdata, ram_addr, ram_wdata, ram_rdata;

    logic       req_s, req_l;
    logic       s_gnt0, s_gnt1, s_done0, s_done1, s_busy, s_we;
    logic [7:0] s_rdata, s_addr, s_wdata;
    logic       l_gnt0, l_gnt1, l_done0, l_done1, l_busy, l_we;
    logic [7:0] l_rdata, l_addr, l_wdata;

    logic       mem_init;
    logic [7:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= (i == 16) ? 8'hA5 : 8'(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    mem_arbiter #(.WAIT_CYCLES(2)) dut (
        .arb_clk(clk), .arb_rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .busy(busy),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    mem_arbiter #(.WAIT_CYCLES(1)) dut_s (
        .arb_clk(clk), .arb_rst_n(rst_n),
        .req0(req_s), .req1(1'b0), .we0(1'b0), .we1(1'b0),
        .addr0(8'h10), .addr1(8'h00),
        .wdata0(8'h00), .wdata1(8'h00),
        .gnt0(s_gnt0), .gnt1(s_gnt1), .done0(s_done0), .done1(s_done1),
        .rdata(s_rdata), .busy(s_busy),
        .ram_addr(s_addr), .ram_wdata(s_wdata),
        .ram_we(s_we), .ram_rdata(ram_rdata)
    );

    mem_arbiter #(.WAIT_CYCLES(15)) dut_l (
        .arb_clk(clk), .arb_rst_n(rst_n),
        .req0(req_l), .req1(1'b0), .we0(1'b0), .we1(1'b0),
        .addr0(8'h10), .addr1(8'h00),
        .wdata0(8'h00), .wdata1(8'h00),
        .gnt0(l_gnt0), .gnt1(l_gnt1), .done0(l_done0), .done1(l_done1),
        .rdata(l_rdata), .busy(l_busy),
        .ram_addr(l_addr), .ram_wdata(l_wdata),
        .ram_we(l_we), .ram_rdata(ram_rdata)
    );

    typedef struct {
        logic       r0;
        logic       r1;
        logic       w0;
        logic       w1;
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       port;
        logic [7:0] rd;
        int         nwe;
        logic [7:0] wa;
        logic [7:0] wd;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int         cyc = 0;
        int         first = 0;
        int         wec = 0;
        logic [7:0] wa = 8'h00;
        logic [7:0] wd = 8'h00;
        logic       fin = 1'b0;
        logic       ovl = 1'b0;
        logic [1:0] gsn = 2'b00;
        logic [1:0] dsn = 2'b00;
        req0 = v.r0; req1 = v.r1; we0 = v.w0; we1 = v.w1;
        addr0 = v.a0; addr1 = v.a1; wdata0 = v.d0; wdata1 = v.d1;
        for (int i = 1; i <= 40 && !fin; i++) begin
            @(posedge clk); #1;
            if (gnt0 && gnt1) ovl = 1'b1;
            if (gnt0 || gnt1) begin
                cyc++;
                if (first == 0) first = i;
            end
            if (ram_we) begin
                wec++;
                wa = ram_addr;
                wd = ram_wdata;
            end
            if (done0 || done1) begin
                fin = 1'b1;
                gsn = {gnt1, gnt0};
                dsn = {done1, done0};
            end
        end
        check($sformatf("v%0d done_seen", idx), 32'(fin), 32'd1);
        check($sformatf("v%0d gnt_edge", idx), 32'(first), 32'd1);
        check($sformatf("v%0d done_owner", idx), 32'(dsn),
              v.port ? 32'd2 : 32'd1);
        check($sformatf("v%0d gnt_owner", idx), 32'(gsn),
              v.port ? 32'd2 : 32'd1);
        check($sformatf("v%0d latency", idx), 32'(cyc), 32'd3);
        check($sformatf("v%0d rdata", idx), 32'(rdata), 32'(v.rd));
        check($sformatf("v%0d we_cycles", idx), 32'(wec), 32'(v.nwe));
        check($sformatf("v%0d we_addr", idx), 32'(wa), 32'(v.wa));
        check($sformatf("v%0d we_data", idx), 32'(wd), 32'(v.wd));
        check($sformatf("v%0d overlap", idx), 32'(ovl), 32'd0);
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        check($sformatf("v%0d idle", idx),
              {16'h0, busy, gnt0, gnt1, done0, done1, ram_we, 2'b0, ram_addr},
              32'd0);
    endtask

    initial begin
        logic       owners [4];
        int         ng;
        logic       prev;
        logic       ovl;
        int         dn;
        int         bad;
        logic [7:0] rd;
        int         cyc;
        logic       fin;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 8'h00,
                   1'b0, 8'hA5, 0, 8'h00, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h20, 8'h00, 8'h3C,
                   1'b1, 8'hA5, 1, 8'h20, 8'h3C};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 8'h00, 8'h00,
                   1'b0, 8'h3C, 0, 8'h00, 8'h00};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 8'h10, 8'h00, 8'h00,
                   1'b1, 8'hA5, 0, 8'h00, 8'h00};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h40, 8'h10, 8'h77, 8'h00,
                   1'b0, 8'hA5, 1, 8'h40, 8'h77};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h40, 8'h00, 8'h00,
                   1'b1, 8'h77, 0, 8'h00, 8'h00};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 8'h06, 8'h00, 8'h00,
                   1'b0, 8'h05, 0, 8'h00, 8'h00};

        rst_n = 1'b0; mem_init = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
        req_s = 1'b0; req_l = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst ctrl", {26'h0, gnt0, gnt1, done0, done1, busy, ram_we}, 32'd0);
        check("rst rdata", 32'(rdata), 32'd0);
        check("rst ram_addr", 32'(ram_addr), 32'd0);
        check("rst ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst aux busy", {30'h0, s_busy, l_busy}, 32'd0);

        // Both ports requesting from reset: port 0 must win first.
        req0 = 1'b1; req1 = 1'b1; addr0 = 8'h10; addr1 = 8'h20;
        @(negedge clk);
        rst_n = 1'b1; mem_init = 1'b0;
        ng = 0; prev = 1'b0; ovl = 1'b0;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            @(posedge clk); #1;
            if (gnt0 && gnt1) ovl = 1'b1;
            if ((gnt0 || gnt1) && !prev) begin
                owners[ng] = gnt1;
                ng++;
            end
            prev = gnt0 || gnt1;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr count", 32'(ng), 32'd4);
        for (int k = 0; k < 4; k++)
            check($sformatf("rr grant%0d", k), 32'(owners[k]), 32'(k % 2));
        for (int i = 0; i < 10 && busy; i++) begin
            @(posedge clk); #1;
            if (gnt0 && gnt1) ovl = 1'b1;
        end
        check("rr overlap", 32'(ovl), 32'd0);
        check("rr idle", 32'(busy), 32'd0);

        for (int v = 0; v < 7; v++)
            run_txn(tbl[v], v);

        // Port 1 drops req and moves addr after the grant.
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
        @(posedge clk); #1;
        check("drop gnt1", 32'(gnt1), 32'd1);
        @(posedge clk); #1;
        req1 = 1'b0; addr1 = 8'hFF;
        dn = 0; bad = 0; rd = 8'h00;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (busy && ram_addr !== 8'h20) bad++;
            if (done1) begin
                dn++;
                rd = rdata;
            end
        end
        check("drop done1 count", 32'(dn), 32'd1);
        check("drop rdata", 32'(rd), 32'h3C);
        check("drop addr held", 32'(bad), 32'd0);

        // Reset in the second ACCESS cycle.
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        @(posedge clk); #1;
        check("rstmid gnt0", 32'(gnt0), 32'd1);
        @(posedge clk); #1;
        check("rstmid busy", 32'(busy), 32'd1);
        rst_n = 1'b0; req0 = 1'b0;
        #1;
        check("rstmid ctrl", {26'h0, gnt0, gnt1, done0, done1, busy, ram_we}, 32'd0);
        check("rstmid data", {8'h0, rdata, ram_addr, ram_wdata}, 32'd0);
        dn = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done0 || done1) dn++;
        end
        check("rstmid no done", 32'(dn), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(tbl[0], 100);

        // Latency at the WAIT_CYCLES extremes.
        req_s = 1'b1;
        cyc = 0; fin = 1'b0;
        for (int i = 0; i < 40 && !fin; i++) begin
            @(posedge clk); #1;
            if (s_gnt0) cyc++;
            if (s_done0) fin = 1'b1;
        end
        req_s = 1'b0;
        check("w1 done", 32'(fin), 32'd1);
        check("w1 latency", 32'(cyc), 32'd2);

        req_l = 1'b1;
        cyc = 0; fin = 1'b0;
        for (int i = 0; i < 40 && !fin; i++) begin
            @(posedge clk); #1;
            if (l_gnt0) cyc++;
            if (l_done0) fin = 1'b1;
        end
        req_l = 1'b0;
        check("w15 done", 32'(fin), 32'd1);
        check("w15 latency", 32'(cyc), 32'd16);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SHALL set RAM access cycles per transaction; legal range 1..15.
REQ-002 arb_clk  input  1  single clock; all state changes on rising edge.
REQ-003 arb_rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-004 req0, req1  input  1 each  access request; 0 = instruction fetch port, 1 = data (LD/ST) port.
REQ-005 we0, we1  input  1 each  write enable (1 = write, 0 = read) per port.
REQ-006 addr0, addr1  input  8 each  RAM address per port.
REQ-007 wdata0, wdata1  input  8 each  write data per port.
REQ-008 gnt0, gnt1  output  1 each  registered; high for the whole transaction owned by that port.
REQ-009 done0, done1  output  1 each  one-cycle completion pulse per port.
REQ-010 rdata  output  8  read data; valid in the done cycle of a read.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 ram_addr  output  8; ram_wdata  output  8; ram_we  output  1; ram_rdata  input  8  single-port RAM interface, synchronous read, data valid one cycle after address.

Function
REQ-013 FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-014 IDLE: no req -> stay IDLE; any req -> at next edge enter ACCESS, assert winner's gnt, latch winner's addr/we/wdata.
REQ-015 Arbitration: one req high -> that port wins; both high -> port not granted last wins (round-robin).
REQ-016 After reset, last-granted pointer SHALL indicate port 1, so port 0 wins the first tie.
REQ-017 ACCESS SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter loaded on entry.
REQ-018 ram_addr/ram_wdata SHALL drive latched values throughout ACCESS and RESP; 0x00 in IDLE.
REQ-019 ram_we SHALL be high only in the first ACCESS cycle, and only for a write.
REQ-020 ACCESS end -> RESP: rdata <= ram_rdata for reads; rdata unchanged for writes.
REQ-021 RESP SHALL last one cycle: owner's done high, gnt held; next edge -> IDLE, gnt cleared, pointer updated to owner.
REQ-022 Grant-to-done latency SHALL be WAIT_CYCLES+1 cycles; IDLE idles at least one cycle between transactions.
REQ-023 Requester SHALL hold addr/we/wdata until done; arbiter ignores input changes after the latch.
REQ-024 req dropped mid-transaction SHALL NOT abort; transaction completes and done still pulses.
REQ-025 req still high in IDLE after done SHALL be treated as a new request.
REQ-026 gnt0 and gnt1 SHALL never be high simultaneously; done only for the current owner.

Reset
REQ-027 arb_rst_n low SHALL immediately force IDLE, counter 0, pointer = port 1, and all outputs (gnt*, done*, rdata, busy, ram_addr, ram_wdata, ram_we) to 0.
REQ-028 Reset during ACCESS/RESP SHALL abort with no done pulse; ram_we drops asynchronously.
REQ-029 After release, first edge with a req high SHALL start a normal transaction.

Verification (WAIT_CYCLES=2)
REQ-030 Port-0 read addr 0x10, RAM[0x10]=0xA5 -> gnt0 next edge, done0 3 cycles later, rdata=0xA5, ram_we never high.
REQ-031 Port-1 write addr 0x20 data 0x3C -> ram_we high exactly one cycle with ram_addr=0x20, ram_wdata=0x3C; done1 pulses; rdata unchanged.
REQ-032 req0 and req1 held high from reset -> grants alternate 0,1,0,1; gnt0/gnt1 never overlap.
REQ-033 Reset asserted in second ACCESS cycle -> all outputs 0 same cycle, no done; after release port-0 read of 0x10 completes normally with rdata=0xA5.
REQ-034 req1 dropped and addr1 changed to 0xFF one cycle after gnt1 -> transaction finishes at original address, done1 pulses once.
REQ-035 WAIT_CYCLES=1 and 15 -> grant-to-done latency 2 and 16 cycles respectively.
